// File: rtl/shots_pkg.sv
// Shared types and colour constants for the shots pool.
//   shot_t                 per-slot state: active flag, owner, top-left position
//   SHOT_PLAYER_COLOR      RGB332 colour of player shots
//   SHOT_ENEMY_COLOR       RGB332 colour of enemy shots
//   TRANSPARENT_COLOR      "nothing drawn" colour for the VGA object mux
package shots_pkg;

  typedef struct packed {
    logic        active;
    logic        owner_player;
    logic [10:0] x;
    logic [10:0] y;
  } shot_t;

  localparam logic [7:0] SHOT_PLAYER_COLOR = 8'h1C;
  localparam logic [7:0] SHOT_ENEMY_COLOR  = 8'hE0;
  localparam logic [7:0] TRANSPARENT_COLOR = 8'hFF;

endpackage

// File: rtl/shots_arbiter.sv
// Picks one pending shooter per clock.
//   clk, resetN   clock, synchronous active-low reset
//   clear         level restart: drops the grant and rewinds the pointer
//   pending       one bit per shooter; index ENEMY_BIKERS_COUNT is the player
//   freeSlot      at least one pool slot is free this cycle
//   grantValid    a shooter is granted this cycle
//   grantIdx      index of the granted shooter
// The player always wins; enemies are served round-robin, the search
// starting at the enemy after the last one granted.
module shots_arbiter
  import shots_pkg::*;
#(
  parameter int unsigned ENEMY_BIKERS_COUNT = 8,
  localparam int unsigned IDX_W = $clog2(ENEMY_BIKERS_COUNT + 1)
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      clear,
  input  logic [ENEMY_BIKERS_COUNT:0] pending,
  input  logic                      freeSlot,
  output logic                      grantValid,
  output logic [IDX_W-1:0]          grantIdx
);

  logic [IDX_W-1:0] rrPtr;
  int unsigned      cand;

  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    cand       = 0;
    if (!clear && freeSlot) begin
      if (pending[ENEMY_BIKERS_COUNT]) begin
        grantValid = 1'b1;
        grantIdx   = IDX_W'(ENEMY_BIKERS_COUNT);
      end else begin
        for (int unsigned off = 0; off < ENEMY_BIKERS_COUNT; off++) begin
          cand = int'(rrPtr) + off;
          if (cand >= ENEMY_BIKERS_COUNT) cand = cand - ENEMY_BIKERS_COUNT;
          if (!grantValid && pending[cand]) begin
            grantValid = 1'b1;
            grantIdx   = IDX_W'(cand);
          end
        end
      end
    end
  end

  // rrPtr holds the first enemy index to consider next time.
  always_ff @(posedge clk) begin
    if (!resetN || clear) begin
      rrPtr <= '0;
    end else if (grantValid && grantIdx != IDX_W'(ENEMY_BIKERS_COUNT)) begin
      rrPtr <= (grantIdx == IDX_W'(ENEMY_BIKERS_COUNT - 1)) ? '0 : grantIdx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/shots_pool.sv
// Fixed pool of shot slots fed by biker shoot requests.
//   clk, resetN          clock, synchronous active-low reset
//   startOfFrame         per-frame pulse: moves shots, ages cooldowns
//   startOfLevel         clears every slot, pending request and cooldown
//   enemyShootRequest    per-enemy shoot pulse
//   playerShootRequest   player shoot pulse
//   bikersX / bikersY    biker top-left positions; last entry is the player
//   shotCollision        per-slot hit, retires the slot
//   pixelX / pixelY      current VGA pixel
//   shotOwnerPlayer      slot holds a live player shot
//   shotDrawingVector    pixel lies inside live slot i (1 clk latency)
//   RGBout               merged shot colour, transparent when none
// Optional feature: define SHOTS_POOL_AIM_EN to make enemy shots drift 1 px
// per frame horizontally toward the player's muzzle.
module shots_pool
  import shots_pkg::*;
#(
  parameter int unsigned ENEMY_BIKERS_COUNT = 8,
  parameter int unsigned SHOTS_COUNT        = 8,
  parameter int unsigned SHOT_W             = 4,
  parameter int unsigned SHOT_H             = 8,
  parameter int unsigned PLAYER_SHOT_SPEED  = 6,
  parameter int unsigned ENEMY_SHOT_SPEED   = 3,
  parameter int unsigned COOLDOWN_FRAMES    = 15,
  parameter int unsigned Y_BOTTOM_LIMIT     = 479
) (
  input  logic                               clk,
  input  logic                               resetN,
  input  logic                               startOfFrame,
  input  logic                               startOfLevel,
  input  logic [ENEMY_BIKERS_COUNT-1:0]      enemyShootRequest,
  input  logic                               playerShootRequest,
  input  logic [ENEMY_BIKERS_COUNT:0][10:0]  bikersX,
  input  logic [ENEMY_BIKERS_COUNT:0][10:0]  bikersY,
  input  logic [SHOTS_COUNT-1:0]             shotCollision,
  input  logic [10:0]                        pixelX,
  input  logic [10:0]                        pixelY,
  output logic [SHOTS_COUNT-1:0]             shotOwnerPlayer,
  output logic [SHOTS_COUNT-1:0]             shotDrawingVector,
  output logic [7:0]                         RGBout
);

  localparam int unsigned IDX_W  = $clog2(ENEMY_BIKERS_COUNT + 1);
  localparam int unsigned SLOT_W = (SHOTS_COUNT > 1) ? $clog2(SHOTS_COUNT) : 1;
  localparam int unsigned CD_W   = $clog2(COOLDOWN_FRAMES + 1);

  shot_t                     slots [SHOTS_COUNT];
  logic [ENEMY_BIKERS_COUNT:0] pending;
  logic [ENEMY_BIKERS_COUNT:0] shootReq;
  logic [CD_W-1:0]           cooldown [ENEMY_BIKERS_COUNT+1];

  logic                      freeAvail;
  logic [SLOT_W-1:0]         freeIdx;
  logic                      grantValid;
  logic [IDX_W-1:0]          grantIdx;
  logic                      grantPlayer;
  shot_t                     spawnShot;

  logic [SHOTS_COUNT-1:0]    hitVec;
  logic [SHOTS_COUNT-1:0]    ownerVec;

  assign shootReq    = {playerShootRequest, enemyShootRequest};
  assign grantPlayer = (grantIdx == IDX_W'(ENEMY_BIKERS_COUNT));

`ifdef SHOTS_POOL_AIM_EN
  logic [10:0] aimX;
  assign aimX = bikersX[ENEMY_BIKERS_COUNT] + 11'd14;
`endif

  // Freedom comes from registered state, so a slot retired this cycle only
  // becomes eligible on the next one.
  always_comb begin
    freeAvail = 1'b0;
    freeIdx   = '0;
    for (int unsigned i = SHOTS_COUNT; i > 0; i--) begin
      if (!slots[i-1].active) begin
        freeAvail = 1'b1;
        freeIdx   = SLOT_W'(i - 1);
      end
    end
  end

  shots_arbiter #(.ENEMY_BIKERS_COUNT(ENEMY_BIKERS_COUNT)) arbiter (
    .clk        (clk),
    .resetN     (resetN),
    .clear      (startOfLevel),
    .pending    (pending),
    .freeSlot   (freeAvail),
    .grantValid (grantValid),
    .grantIdx   (grantIdx)
  );

  always_comb begin
    spawnShot              = '0;
    spawnShot.active       = 1'b1;
    spawnShot.owner_player = grantPlayer;
    spawnShot.x            = bikersX[grantIdx] + 11'd14;
    spawnShot.y            = grantPlayer ? bikersY[grantIdx] - 11'(SHOT_H)
                                         : bikersY[grantIdx] + 11'd32;
  end

  // One frame step for a live slot; returns an empty slot when it leaves the
  // screen. The player check happens before subtracting so y never wraps.
  function automatic shot_t moveShot(input shot_t s);
    shot_t       n;
    logic [11:0] down;
    n    = s;
    down = {1'b0, s.y} + 12'(ENEMY_SHOT_SPEED);
    if (s.owner_player) begin
      if (s.y < 11'(PLAYER_SHOT_SPEED)) n = '0;
      else                              n.y = s.y - 11'(PLAYER_SHOT_SPEED);
    end else if (down > 12'(Y_BOTTOM_LIMIT)) begin
      n = '0;
    end else begin
      n.y = down[10:0];
`ifdef SHOTS_POOL_AIM_EN
      if (s.x < aimX)      n.x = s.x + 11'd1;
      else if (s.x > aimX) n.x = s.x - 11'd1;
`endif
    end
    return n;
  endfunction

  // Collision and move only touch live slots, spawn only free ones, so the
  // level > collision > move > spawn order falls out of the branch structure.
  always_ff @(posedge clk) begin
    if (!resetN || startOfLevel) begin
      for (int unsigned i = 0; i < SHOTS_COUNT; i++) slots[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < SHOTS_COUNT; i++) begin
        if (slots[i].active) begin
          if (shotCollision[i])  slots[i] <= '0;
          else if (startOfFrame) slots[i] <= moveShot(slots[i]);
        end else if (grantValid && freeIdx == SLOT_W'(i)) begin
          slots[i] <= spawnShot;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN || startOfLevel) begin
      pending <= '0;
      for (int unsigned k = 0; k <= ENEMY_BIKERS_COUNT; k++) cooldown[k] <= '0;
    end else begin
      for (int unsigned k = 0; k <= ENEMY_BIKERS_COUNT; k++) begin
        if (grantValid && grantIdx == IDX_W'(k)) begin
          pending[k]  <= 1'b0;
          cooldown[k] <= CD_W'(COOLDOWN_FRAMES);
        end else begin
          if (shootReq[k] && cooldown[k] == '0) pending[k] <= 1'b1;
          if (startOfFrame && cooldown[k] != '0) cooldown[k] <= cooldown[k] - CD_W'(1);
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < SHOTS_COUNT; i++) begin
      ownerVec[i] = slots[i].active && slots[i].owner_player;
      hitVec[i]   = slots[i].active
                 && (pixelX >= slots[i].x)
                 && ({1'b0, pixelX} < {1'b0, slots[i].x} + 12'(SHOT_W))
                 && (pixelY >= slots[i].y)
                 && ({1'b0, pixelY} < {1'b0, slots[i].y} + 12'(SHOT_H));
    end
  end

  assign shotOwnerPlayer = ownerVec;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      shotDrawingVector <= '0;
      RGBout            <= TRANSPARENT_COLOR;
    end else begin
      shotDrawingVector <= hitVec;
      if (|(hitVec & ownerVec))       RGBout <= SHOT_PLAYER_COLOR;
      else if (|(hitVec & ~ownerVec)) RGBout <= SHOT_ENEMY_COLOR;
      else                            RGBout <= TRANSPARENT_COLOR;
    end
  end

endmodule

// File: tb/tb_shots_pool.sv
// Directed bench for shots_pool (default build, aiming disabled).
module tb_shots_pool;
  import shots_pkg::*;

  logic              clk = 1'b0;
  logic              resetN;
  logic              startOfFrame;
  logic              startOfLevel;
  logic [7:0]        enemyShootRequest;
  logic              playerShootRequest;
  logic [8:0][10:0]  bikersX;
  logic [8:0][10:0]  bikersY;
  logic [7:0]        shotCollision;
  logic [10:0]       pixelX;
  logic [10:0]       pixelY;
  logic [7:0]        shotOwnerPlayer;
  logic [7:0]        shotDrawingVector;
  logic [7:0]        RGBout;

  int nVec = 0;
  int nMis = 0;

  shots_pool #(.ENEMY_BIKERS_COUNT(8), .SHOTS_COUNT(8)) dut (
    .clk                (clk),
    .resetN             (resetN),
    .startOfFrame       (startOfFrame),
    .startOfLevel       (startOfLevel),
    .enemyShootRequest  (enemyShootRequest),
    .playerShootRequest (playerShootRequest),
    .bikersX            (bikersX),
    .bikersY            (bikersY),
    .shotCollision      (shotCollision),
    .pixelX             (pixelX),
    .pixelY             (pixelY),
    .shotOwnerPlayer    (shotOwnerPlayer),
    .shotDrawingVector  (shotDrawingVector),
    .RGBout             (RGBout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         px;
    int         py;
    logic [7:0] eVec;
    logic [7:0] eRgb;
  } vec_t;

  vec_t tbl [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic probe(input string name, input int px, input int py,
                       input logic [7:0] eVec, input logic [7:0] eRgb);
    pixelX = 11'(px);
    pixelY = 11'(py);
    tick();
    chk({name, "_vec"}, shotDrawingVector, eVec);
    chk({name, "_rgb"}, RGBout, eRgb);
  endtask

  task automatic frame(input int n);
    repeat (n) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
    end
  endtask

  task automatic level();
    startOfLevel = 1'b1;
    tick();
    startOfLevel = 1'b0;
    tick();
  endtask

  task automatic playerShot();
    playerShootRequest = 1'b1;
    tick();
    playerShootRequest = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    resetN = 1'b0;
    startOfFrame = 1'b0;
    startOfLevel = 1'b0;
    enemyShootRequest = '0;
    playerShootRequest = 1'b0;
    shotCollision = '0;
    pixelX = '0;
    pixelY = '0;
    for (int k = 0; k < 8; k++) begin
      bikersX[k] = 11'(40 * k + 2);
      bikersY[k] = 11'd100;
    end
    bikersX[8] = 11'd304;
    bikersY[8] = 11'd430;

    // Player shot at (318,422), size 4x8.
    tbl[0] = '{318, 422, 8'h01, 8'h1C};
    tbl[1] = '{317, 422, 8'h00, 8'hFF};
    tbl[2] = '{321, 429, 8'h01, 8'h1C};
    tbl[3] = '{322, 429, 8'h00, 8'hFF};
    tbl[4] = '{318, 430, 8'h00, 8'hFF};
    tbl[5] = '{320, 425, 8'h01, 8'h1C};
    tbl[6] = '{318, 421, 8'h00, 8'hFF};

    tick();
    tick();
    chk("rst_owner", shotOwnerPlayer, 8'h00);
    chk("rst_vec", shotDrawingVector, 8'h00);
    chk("rst_rgb", RGBout, 8'hFF);
    resetN = 1'b1;
    tick();

    // Player spawn: request latched on first edge, granted on the next.
    playerShootRequest = 1'b1;
    tick();
    playerShootRequest = 1'b0;
    chk("spawn_latency_owner", shotOwnerPlayer, 8'h00);
    tick();
    chk("spawn_owner", shotOwnerPlayer, 8'h01);
    for (int v = 0; v < 7; v++) begin
      pixelX = 11'(tbl[v].px);
      pixelY = 11'(tbl[v].py);
      tick();
      chk($sformatf("tbl%0d_vec", v), shotDrawingVector, tbl[v].eVec);
      chk($sformatf("tbl%0d_rgb", v), RGBout, tbl[v].eRgb);
    end

    frame(2);
    probe("move2_top", 318, 410, 8'h01, 8'h1C);
    probe("move2_above", 318, 409, 8'h00, 8'hFF);
    probe("move2_bot", 318, 417, 8'h01, 8'h1C);
    probe("move2_below", 318, 418, 8'h00, 8'hFF);

    frame(3);
    playerShot();
    chk("cooldown10_owner", shotOwnerPlayer, 8'h01);
    frame(9);
    playerShot();
    chk("cooldown1_owner", shotOwnerPlayer, 8'h01);
    frame(1);
    playerShot();
    chk("cooldown0_owner", shotOwnerPlayer, 8'h03);
    probe("second_shot", 318, 422, 8'h02, 8'h1C);
    probe("first_shot_aged", 318, 332, 8'h01, 8'h1C);

    // Top-edge retirement without wrap: y 28 -> 22,16,10,4 -> retired.
    level();
    bikersY[8] = 11'd36;
    playerShot();
    frame(4);
    probe("top_y4", 318, 4, 8'h01, 8'h1C);
    frame(1);
    chk("top_retired_owner", shotOwnerPlayer, 8'h00);
    probe("top_gone", 318, 4, 8'h00, 8'hFF);
    probe("top_nowrap", 318, 2046, 8'h00, 8'hFF);
    bikersY[8] = 11'd430;

    // Everyone requests at once with 8 slots.
    level();
    enemyShootRequest = 8'hFF;
    playerShootRequest = 1'b1;
    tick();
    enemyShootRequest = '0;
    playerShootRequest = 1'b0;
    tick();
    chk("burst_player_first", shotOwnerPlayer, 8'h01);
    repeat (8) tick();
    chk("burst_owner", shotOwnerPlayer, 8'h01);
    for (int k = 0; k < 7; k++) begin
      logic [7:0] expv;
      expv = 8'h01 << (k + 1);
      probe($sformatf("burst_enemy%0d", k), 40 * k + 16, 132, expv, 8'hE0);
    end
    probe("burst_e7_held", 296, 132, 8'h00, 8'hFF);
    shotCollision = 8'h08;
    tick();
    shotCollision = '0;
    probe("retire_not_reused", 296, 132, 8'h00, 8'hFF);
    probe("e7_granted", 296, 132, 8'h08, 8'hE0);
    probe("e2_retired", 96, 132, 8'h00, 8'hFF);

    // Pool full, all pending, then a level start drops everything.
    frame(15);
    enemyShootRequest = 8'hFF;
    playerShootRequest = 1'b1;
    tick();
    tick();
    startOfLevel = 1'b1;
    tick();
    startOfLevel = 1'b0;
    enemyShootRequest = '0;
    playerShootRequest = 1'b0;
    repeat (4) tick();
    chk("level_clears_pending", shotOwnerPlayer, 8'h00);
    probe("level_no_enemy", 16, 132, 8'h00, 8'hFF);
    probe("level_no_player", 318, 422, 8'h00, 8'hFF);

    // Overlap: player shot (318,422), enemy0 shot (320,422), enemy1 shot (114,132).
    bikersX[0] = 11'd306;
    bikersY[0] = 11'd390;
    bikersX[1] = 11'd100;
    enemyShootRequest = 8'h03;
    playerShootRequest = 1'b1;
    tick();
    enemyShootRequest = '0;
    playerShootRequest = 1'b0;
    repeat (3) tick();
    chk("overlap_owner", shotOwnerPlayer, 8'h01);
    probe("overlap_both", 320, 425, 8'h03, 8'h1C);
    probe("overlap_player", 318, 425, 8'h01, 8'h1C);
    probe("overlap_edge", 322, 425, 8'h02, 8'hE0);
    probe("overlap_enemy_br", 323, 429, 8'h02, 8'hE0);
    probe("overlap_none", 324, 425, 8'h00, 8'hFF);
    probe("slot2_live", 114, 132, 8'h04, 8'hE0);

    // Collision on slot 2 together with a frame tick.
    shotCollision = 8'h04;
    startOfFrame = 1'b1;
    tick();
    shotCollision = '0;
    startOfFrame = 1'b0;
    probe("coll_old_pos", 114, 132, 8'h00, 8'hFF);
    probe("coll_moved_pos", 114, 135, 8'h00, 8'hFF);
    probe("coll_player_moved", 318, 416, 8'h01, 8'h1C);
    probe("coll_player_above", 318, 415, 8'h00, 8'hFF);
    probe("coll_enemy_moved", 323, 425, 8'h02, 8'hE0);
    probe("coll_enemy_above", 323, 424, 8'h00, 8'hFF);

    // Third live shot, then reset in flight.
    enemyShootRequest = 8'h04;
    tick();
    enemyShootRequest = '0;
    tick();
    probe("third_shot", 96, 132, 8'h04, 8'hE0);
    probe("pre_reset", 320, 425, 8'h02, 8'hE0);
    resetN = 1'b0;
    tick();
    chk("midrst_owner", shotOwnerPlayer, 8'h00);
    chk("midrst_vec", shotDrawingVector, 8'h00);
    chk("midrst_rgb", RGBout, 8'hFF);
    resetN = 1'b1;
    probe("post_reset_a", 320, 425, 8'h00, 8'hFF);
    probe("post_reset_b", 96, 132, 8'h00, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
